// File: rtl/mips_load_dump_ctrl.sv
// Run sequencer for one MIPS_processor test: load the instruction image, pulse processor
// reset, run until halt or timeout, then stream out the register file, PC and data memory.
module mips_load_dump_ctrl #(
    parameter int          IMEM_WORDS = 8192,
    parameter int          DMEM_WORDS = 8192,
    parameter int          DM_AW      = 13,
    parameter int          RF_REGS    = 32,
    parameter int          RST_CYCLES = 2,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter int          MAX_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    output logic              wr,
    output logic [31:0]       write_address,
    output logic [31:0]       instruc_data,
    output logic              proc_reset,
    input  logic [31:0]       inst,
    input  logic [31:0]       pc,
    output logic [4:0]        tb_add,
    input  logic [31:0]       tb_da,
    output logic [DM_AW-1:0]  tb_address,
    input  logic [31:0]       tb_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       run_cycles
);

    localparam logic [31:0] LOAD_LAST = 32'(IMEM_WORDS - 1);
    localparam logic [31:0] PRST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] RUN_LAST  = 32'(MAX_CYCLES - 1);
    localparam logic [31:0] PC_IDX    = 32'(RF_REGS);
    localparam logic [31:0] DM_BASE   = 32'(RF_REGS + 1);
    localparam logic [31:0] DUMP_LAST = 32'(RF_REGS + DMEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRST,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        wr_reg, wr_next;
    logic [31:0] waddr_reg, waddr_next;
    logic [31:0] idata_reg, idata_next;
    logic        dvalid_reg, dvalid_next;
    logic [31:0] ddata_reg, ddata_next;
    logic        dlast_reg, dlast_next;
    logic        timeout_reg, timeout_next;
    logic [31:0] runcyc_reg, runcyc_next;

    logic             accept;
    logic [DM_AW-1:0] dm_index;
    logic [31:0]      dump_src;

    assign ld_ready   = (state_reg == S_LOAD);
    assign accept     = ld_valid & ld_ready;
    assign proc_reset = (state_reg == S_PRST);
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done       = (state_reg == S_DONE);

    // Debug read addresses come straight from the registered dump index so the
    // combinational read data is valid in the same cycle it is captured.
    assign dm_index   = DM_AW'(cnt_reg - DM_BASE);
    assign tb_add     = (state_reg == S_DUMP && cnt_reg < PC_IDX) ? cnt_reg[4:0] : 5'd0;
    assign tb_address = (state_reg == S_DUMP && cnt_reg > PC_IDX) ? dm_index : '0;

    always_comb begin
        dump_src = tb_data;
        if (cnt_reg < PC_IDX)
            dump_src = tb_da;
        else if (cnt_reg == PC_IDX)
            dump_src = pc;
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        wr_next      = 1'b0;
        waddr_next   = waddr_reg;
        idata_next   = idata_reg;
        dvalid_next  = dvalid_reg;
        ddata_next   = ddata_reg;
        dlast_next   = dlast_reg;
        timeout_next = timeout_reg;
        runcyc_next  = runcyc_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next   = S_LOAD;
                    cnt_next     = 32'd0;
                    timeout_next = 1'b0;
                    runcyc_next  = 32'd0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_next    = 1'b1;
                    waddr_next = {cnt_reg[29:0], 2'b00};
                    idata_next = ld_data;
                    if (cnt_reg == LOAD_LAST) begin
                        state_next = S_PRST;
                        cnt_next   = 32'd0;
                    end else begin
                        cnt_next = cnt_reg + 32'd1;
                    end
                end
            end
            S_PRST: begin
                if (cnt_reg == PRST_LAST) begin
                    state_next = S_RUN;
                    cnt_next   = 32'd0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            S_RUN: begin
                runcyc_next = runcyc_reg + 32'd1;
                if (inst == HALT_WORD) begin
                    state_next = S_DUMP;
                end else if (runcyc_reg == RUN_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = S_DUMP;
                end
            end
            S_DUMP: begin
                if (dvalid_reg && dump_ready && dlast_reg) begin
                    state_next  = S_DONE;
                    dvalid_next = 1'b0;
                    dlast_next  = 1'b0;
                end else if (!dvalid_reg || dump_ready) begin
                    ddata_next  = dump_src;
                    dvalid_next = 1'b1;
                    dlast_next  = (cnt_reg == DUMP_LAST);
                    cnt_next    = cnt_reg + 32'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 32'd0;
            wr_reg      <= 1'b0;
            waddr_reg   <= 32'd0;
            idata_reg   <= 32'd0;
            dvalid_reg  <= 1'b0;
            ddata_reg   <= 32'd0;
            dlast_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            runcyc_reg  <= 32'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wr_reg      <= wr_next;
            waddr_reg   <= waddr_next;
            idata_reg   <= idata_next;
            dvalid_reg  <= dvalid_next;
            ddata_reg   <= ddata_next;
            dlast_reg   <= dlast_next;
            timeout_reg <= timeout_next;
            runcyc_reg  <= runcyc_next;
        end
    end

    assign wr            = wr_reg;
    assign write_address = waddr_reg;
    assign instruc_data  = idata_reg;
    assign dump_valid    = dvalid_reg;
    assign dump_data     = ddata_reg;
    assign dump_last     = dlast_reg;
    assign timeout       = timeout_reg;
    assign run_cycles    = runcyc_reg;

endmodule

// File: tb/tb_mips_load_dump_ctrl.sv
// Directed bench for mips_load_dump_ctrl with a small image (4 instr / 4 data words).
module tb_mips_load_dump_ctrl;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = 32'd0;
    logic        wr;
    logic [31:0] write_address;
    logic [31:0] instruc_data;
    logic        proc_reset;
    logic [31:0] inst = 32'd0;
    logic [31:0] pc;
    logic [4:0]  tb_add;
    logic [31:0] tb_da;
    logic [1:0]  tb_address;
    logic [31:0] tb_data;
    logic        dump_valid;
    logic        dump_ready = 1'b1;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] run_cycles;

    int compared = 0;
    int mismatched = 0;

    // Processor model: register file and data memory with recognisable contents.
    assign tb_da   = 32'h100 + 32'(tb_add);
    assign tb_data = 32'hA000 + 32'(tb_address);
    assign pc      = 32'h40;

    always #5 clk = ~clk;

    mips_load_dump_ctrl #(
        .IMEM_WORDS(4),
        .DMEM_WORDS(4),
        .DM_AW(2),
        .RF_REGS(32),
        .RST_CYCLES(2),
        .HALT_WORD(HALT),
        .MAX_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data(ld_data),
        .wr(wr),
        .write_address(write_address),
        .instruc_data(instruc_data),
        .proc_reset(proc_reset),
        .inst(inst),
        .pc(pc),
        .tb_add(tb_add),
        .tb_da(tb_da),
        .tb_address(tb_address),
        .tb_data(tb_data),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_data(dump_data),
        .dump_last(dump_last),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .run_cycles(run_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {24'd0, ld_ready, wr, proc_reset, dump_valid, dump_last, busy, done, timeout}, 32'd0);
        check({tag, "_waddr"}, write_address, 32'd0);
        check({tag, "_idata"}, instruc_data, 32'd0);
        check({tag, "_ddata"}, dump_data, 32'd0);
        check({tag, "_runcyc"}, run_cycles, 32'd0);
        check({tag, "_dbgaddr"}, {25'd0, tb_add, tb_address}, 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", {31'd0, ld_ready}, 32'd1);
        check("start_busy", {29'd0, busy, done, timeout}, 32'd4);
        check("start_runcyc", run_cycles, 32'd0);
    endtask

    task automatic do_load(input bit gaps, input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1;
            ld_data  = base + 32'(k);
            tick();
            ld_valid = 1'b0;
            check("load_wr", {31'd0, wr}, 32'd1);
            check("load_addr", write_address, 32'(4 * k));
            check("load_data", instruc_data, base + 32'(k));
            if (gaps && k < 3) begin
                tick();
                check("gap_wr", {30'd0, wr, ld_ready}, 32'd1);
            end
        end
        check("prst1", {30'd0, proc_reset, ld_ready}, 32'd2);
        tick();
        check("prst2", {30'd0, proc_reset, wr}, 32'd2);
        tick();
        check("run_entry", {30'd0, proc_reset, busy}, 32'd1);
    endtask

    task automatic do_run_halt(input int n);
        inst = 32'd0;
        repeat (n) tick();
        inst = HALT;
        tick();
        inst = 32'd0;
        check("halt_runcyc", run_cycles, 32'(n + 1));
        check("halt_state", {29'd0, busy, dump_valid, timeout}, 32'd4);
    endtask

    function automatic logic [31:0] dump_word(input int n);
        if (n < 32)
            return 32'h100 + 32'(n);
        else if (n == 32)
            return 32'h40;
        else
            return 32'hA000 + 32'(n - 33);
    endfunction

    task automatic do_dump(input bit toggle);
        int          n = 0;
        bit          stalled = 1'b0;
        bit          finished = 1'b0;
        logic [31:0] held = 32'd0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            dump_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (stalled)
                check("dump_hold", dump_data, held);
            if (dump_valid && dump_ready) begin
                check("dump_data", dump_data, dump_word(n));
                check("dump_last", {31'd0, dump_last}, {31'd0, n == 36});
                if (dump_last)
                    finished = 1'b1;
                n++;
                stalled = 1'b0;
            end else if (dump_valid) begin
                stalled = 1'b1;
                held    = dump_data;
            end
            tick();
        end
        dump_ready = 1'b1;
        check("dump_count", 32'(n), 32'd37);
        check("dump_done", {29'd0, done, busy, dump_valid}, 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        ld_valid = 1'b1;
        #1;
        check("idle_no_ready", {31'd0, ld_ready}, 32'd0);
        ld_valid = 1'b0;

        // Run A: back-to-back load, halt after 10 RUN cycles, free-flowing dump.
        do_start();
        do_load(1'b0, 32'hC0DE_0000);
        do_run_halt(10);
        do_dump(1'b0);
        check("runA_timeout", {31'd0, timeout}, 32'd0);
        check("runA_runcyc_hold", run_cycles, 32'd11);

        // Run B: gapped load, stalled dump.
        do_start();
        do_load(1'b1, 32'hBEEF_0010);
        do_run_halt(3);
        do_dump(1'b1);

        // Run C: never halts, ends by timeout.
        do_start();
        do_load(1'b0, 32'h1234_0000);
        inst = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", {30'd0, busy, proc_reset}, 32'd2);
        for (int i = 0; i < 60 && !timeout; i++)
            tick();
        check("to_flag", {31'd0, timeout}, 32'd1);
        check("to_runcyc", run_cycles, 32'd20);
        do_dump(1'b0);
        check("to_sticky", {30'd0, timeout, done}, 32'd3);

        // Reset in the middle of LOAD.
        do_start();
        ld_valid = 1'b1;
        ld_data  = 32'h5555_0000;
        tick();
        tick();
        ld_valid = 1'b0;
        reset = 1'b1;
        tick();
        check_zero("rst_load");
        reset = 1'b0;
        tick();
        check("rst_load_idle", {30'd0, busy, done}, 32'd0);

        // Reset in the middle of DUMP.
        do_start();
        do_load(1'b0, 32'h7777_0000);
        do_run_halt(2);
        repeat (5) tick();
        check("mid_dump_valid", {31'd0, dump_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check_zero("rst_dump");
        reset = 1'b0;
        repeat (3) tick();
        check("no_partial_dump", {30'd0, dump_valid, busy}, 32'd0);

        // Clean run after the aborts.
        do_start();
        do_load(1'b0, 32'h0BAD_F00D);
        do_run_halt(10);
        do_dump(1'b0);
        check("clean_runcyc", run_cycles, 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
